// File: rtl/motor_drive_ctrl.sv
// -----------------------------------------------------------------------------
// motor_drive_ctrl
// Turns the 4-bit steering code from the line-following direction controller
// into left/right motor PWM and H-bridge polarity. Each motor has a duty ramp-up
// and coasts for a dead-time before its polarity is reversed.
//
// Optional feature: define MOTOR_PIVOT_WATCHDOG_EN to add a pivot watchdog
// (parameter PIVOT_TIMEOUT). It stops both motors and raises cmd_err when a
// ninety pivot is held too long.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   DIR[3:0]     in   steering code
//   Direction    in   1 = travel forwards, 0 = travel backwards
//   motor_l_pwm  out  left motor PWM
//   motor_l_fwd  out  left polarity, 1 = wheel drives forward
//   motor_r_pwm  out  right motor PWM
//   motor_r_fwd  out  right polarity, 1 = wheel drives forward
//   moving       out  either applied duty nonzero
//   cmd_err      out  sampled DIR is undefined (or pivot watchdog tripped)
// -----------------------------------------------------------------------------
module motor_drive_ctrl #(
    parameter int unsigned PWM_PERIOD    = 100_000,
    parameter int unsigned DUTY_CRUISE   = 70_000,
    parameter int unsigned DUTY_VEER     = 40_000,
    parameter int unsigned DUTY_HARD     = 10_000,
    parameter int unsigned DUTY_PIVOT    = 60_000,
    parameter int unsigned RAMP_STEP     = 5_000,
    parameter int unsigned DEADTIME      = 50_000
`ifdef MOTOR_PIVOT_WATCHDOG_EN
    ,
    parameter int unsigned PIVOT_TIMEOUT = 60_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] DIR,
    input  logic       Direction,
    output logic       motor_l_pwm,
    output logic       motor_l_fwd,
    output logic       motor_r_pwm,
    output logic       motor_r_fwd,
    output logic       moving,
    output logic       cmd_err
);

    localparam int unsigned DUTY_W = $clog2(PWM_PERIOD + 1);
    localparam int unsigned SUM_W  = DUTY_W + 1;
    localparam int unsigned DEAD_W = $clog2(DEADTIME + 1);

    localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0] LAST_V   = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] CRUISE_V = DUTY_W'(DUTY_CRUISE);
    localparam logic [DUTY_W-1:0] VEER_V   = DUTY_W'(DUTY_VEER);
    localparam logic [DUTY_W-1:0] HARD_V   = DUTY_W'(DUTY_HARD);
    localparam logic [DUTY_W-1:0] PIVOT_V  = DUTY_W'(DUTY_PIVOT);
    localparam logic [SUM_W-1:0]  STEP_V   = SUM_W'(RAMP_STEP);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    localparam logic [3:0] C_PROCEED  = 4'b0000;
    localparam logic [3:0] C_VEER_R   = 4'b1001;
    localparam logic [3:0] C_HARD_R   = 4'b1010;
    localparam logic [3:0] C_NINETY_R = 4'b1011;
    localparam logic [3:0] C_VEER_L   = 4'b0101;
    localparam logic [3:0] C_HARD_L   = 4'b0110;
    localparam logic [3:0] C_NINETY_L = 4'b0111;
    localparam logic [3:0] C_STOP     = 4'b1111;

    typedef enum logic {
        M_RUN   = 1'b0,
        M_COAST = 1'b1
    } mstate_e;

    // Index 0 = left motor, 1 = right motor throughout.
    logic [3:0]        dir_q;
    logic              direction_q;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    mstate_e           state_q   [2];
    mstate_e           state_d   [2];
    logic [DUTY_W-1:0] applied_q [2];
    logic [DUTY_W-1:0] applied_d [2];
    logic [DEAD_W-1:0] dead_q    [2];
    logic [DEAD_W-1:0] dead_d    [2];
    logic [1:0]        pol_q, pol_d;
    logic [1:0]        pwm_q, pwm_d;
    logic              moving_q, moving_d;
    logic              cmd_err_q, cmd_err_d;

    logic [DUTY_W-1:0] tgt_duty [2];
    logic [1:0]        tgt_pol;
    logic [1:0]        rel_pol;
    logic              wrap;
    logic              pivot_trip;
    logic              pivot_trip_d;

    function automatic logic code_defined(input logic [3:0] code);
        case (code)
            C_PROCEED, C_VEER_R, C_HARD_R, C_NINETY_R,
            C_VEER_L, C_HARD_L, C_NINETY_L, C_STOP: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // One ramp evaluation: rise by at most STEP (saturating at the period), fall at once.
    function automatic logic [DUTY_W-1:0] ramp_next(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
        logic [SUM_W-1:0]  sum;
        logic [DUTY_W-1:0] sat;
        sum = {1'b0, cur} + STEP_V;
        sat = (sum > {1'b0, PERIOD_V}) ? PERIOD_V : sum[DUTY_W-1:0];
        if (tgt > cur) begin
            return (sat < tgt) ? sat : tgt;
        end
        return tgt;
    endfunction

`ifdef MOTOR_PIVOT_WATCHDOG_EN
    localparam int unsigned PIV_W = $clog2(PIVOT_TIMEOUT + 1);
    localparam logic [PIV_W-1:0] PIV_MAX = PIV_W'(PIVOT_TIMEOUT);

    logic [PIV_W-1:0] piv_cnt_q, piv_cnt_d;

    // Pivot watchdog: counts while a pivot is held, saturates, clears on any DIR change.
    always_comb begin
        piv_cnt_d = piv_cnt_q;
        if (DIR != dir_q) begin
            piv_cnt_d = '0;
        end else if ((dir_q == C_NINETY_L || dir_q == C_NINETY_R) && piv_cnt_q != PIV_MAX) begin
            piv_cnt_d = piv_cnt_q + PIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            piv_cnt_q <= '0;
        end else begin
            piv_cnt_q <= piv_cnt_d;
        end
    end

    assign pivot_trip   = (piv_cnt_q == PIV_MAX);
    assign pivot_trip_d = (piv_cnt_d == PIV_MAX);
`else
    assign pivot_trip   = 1'b0;
    assign pivot_trip_d = 1'b0;
`endif

    // Steering code to per-wheel target duty and polarity (relative to travel, then absolute).
    always_comb begin
        tgt_duty[0] = '0;
        tgt_duty[1] = '0;
        rel_pol     = 2'b11;
        case (dir_q)
            C_PROCEED:  begin tgt_duty[0] = CRUISE_V; tgt_duty[1] = CRUISE_V; end
            C_VEER_R:   begin tgt_duty[0] = CRUISE_V; tgt_duty[1] = VEER_V;   end
            C_HARD_R:   begin tgt_duty[0] = CRUISE_V; tgt_duty[1] = HARD_V;   end
            C_NINETY_R: begin tgt_duty[0] = PIVOT_V;  tgt_duty[1] = PIVOT_V; rel_pol = 2'b01; end
            C_VEER_L:   begin tgt_duty[0] = VEER_V;   tgt_duty[1] = CRUISE_V; end
            C_HARD_L:   begin tgt_duty[0] = HARD_V;   tgt_duty[1] = CRUISE_V; end
            C_NINETY_L: begin tgt_duty[0] = PIVOT_V;  tgt_duty[1] = PIVOT_V; rel_pol = 2'b10; end
            default:    ;
        endcase
        if (pivot_trip) begin
            tgt_duty[0] = '0;
            tgt_duty[1] = '0;
        end
        // Backwards travel mirrors both wheel polarities.
        tgt_pol = rel_pol ^ {2{~direction_q}};
    end

    assign wrap = (cnt_q == LAST_V);

    // Per-motor RUN/COAST FSMs, PWM counter and registered output next-state.
    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + DUTY_W'(1);
        pol_d     = pol_q;
        pwm_d     = '0;
        cmd_err_d = ~code_defined(DIR) | pivot_trip_d;
        for (int m = 0; m < 2; m++) begin
            state_d[m]   = state_q[m];
            applied_d[m] = applied_q[m];
            dead_d[m]    = dead_q[m];
            case (state_q[m])
                M_RUN: begin
                    if (tgt_pol[m] != pol_q[m] && tgt_duty[m] != '0) begin
                        state_d[m]   = M_COAST;
                        applied_d[m] = '0;
                        dead_d[m]    = '0;
                    end else begin
                        // A reversal with zero target duty needs no coast.
                        pol_d[m] = tgt_pol[m];
                        if (wrap) begin
                            applied_d[m] = ramp_next(applied_q[m], tgt_duty[m]);
                        end
                    end
                end
                M_COAST: begin
                    applied_d[m] = '0;
                    dead_d[m]    = dead_q[m] + DEAD_W'(1);
                    if (dead_q[m] == DEAD_LAST) begin
                        state_d[m] = M_RUN;
                        pol_d[m]   = tgt_pol[m];
                        dead_d[m]  = '0;
                    end else if (tgt_duty[m] != '0 && tgt_pol[m] == pol_q[m]) begin
                        // Reversal cancelled: resume on the current polarity from zero.
                        state_d[m] = M_RUN;
                        dead_d[m]  = '0;
                    end
                end
                default: state_d[m] = M_RUN;
            endcase
            pwm_d[m] = (state_d[m] == M_RUN) &&
                       ((applied_d[m] >= PERIOD_V) || (cnt_d < applied_d[m]));
        end
        moving_d = (applied_d[0] != '0) || (applied_d[1] != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q       <= C_STOP;
            direction_q <= 1'b1;
            cnt_q       <= '0;
            pol_q       <= 2'b11;
            pwm_q       <= 2'b00;
            moving_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            for (int m = 0; m < 2; m++) begin
                state_q[m]   <= M_RUN;
                applied_q[m] <= '0;
                dead_q[m]    <= '0;
            end
        end else begin
            dir_q       <= DIR;
            direction_q <= Direction;
            cnt_q       <= cnt_d;
            pol_q       <= pol_d;
            pwm_q       <= pwm_d;
            moving_q    <= moving_d;
            cmd_err_q   <= cmd_err_d;
            for (int m = 0; m < 2; m++) begin
                state_q[m]   <= state_d[m];
                applied_q[m] <= applied_d[m];
                dead_q[m]    <= dead_d[m];
            end
        end
    end

    assign motor_l_pwm = pwm_q[0];
    assign motor_r_pwm = pwm_q[1];
    assign motor_l_fwd = pol_q[0];
    assign motor_r_fwd = pol_q[1];
    assign moving      = moving_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: doc/motor_drive_ctrl.md
Name: motor_drive_ctrl

Overview:
- Consumes the 4-bit steering code produced by the line-following direction controller.
- Converts it into left and right motor PWM and H-bridge polarity.
- Applies a per-motor duty ramp-up, plus a coast dead-time whenever a motor reverses polarity.
- Sits between the direction controller and the H-bridge pins, in the same clock domain.

Parameters:
- PWM_PERIOD, 100_000: PWM period in clk cycles; counter runs 0..PWM_PERIOD-1.
- DUTY_CRUISE, 70_000: high-count for a motor at normal speed.
- DUTY_VEER, 40_000: inner-wheel duty on a veer.
- DUTY_HARD, 10_000: inner-wheel duty on a hard turn.
- DUTY_PIVOT, 60_000: duty of both wheels on a ninety pivot.
- RAMP_STEP, 5_000: maximum applied-duty increase per PWM period.
- DEADTIME, 50_000: coast cycles inserted before a motor polarity change.
- PIVOT_TIMEOUT, 60_000_000: maximum cycles a ninety pivot is driven (optional feature only).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- DIR, input, 4: steering code from the direction controller.
- Direction, input, 1: 1 = forwards, 0 = backwards travel.
- motor_l_pwm, output, 1: left motor PWM.
- motor_l_fwd, output, 1: left polarity, 1 = wheel drives forward.
- motor_r_pwm, output, 1: right motor PWM.
- motor_r_fwd, output, 1: right polarity, 1 = wheel drives forward.
- moving, output, 1: high when either applied duty is nonzero.
- cmd_err, output, 1: registered; high while the sampled DIR is an undefined code.

Behaviour:
- Reset (async assert, sync release):
  - PWM outputs low, both fwd outputs 1, applied duties 0, targets 0.
  - PWM counter 0, cmd register = STOP (4'b1111), both motor FSMs in RUN, moving=0, cmd_err=0.
- Latency: DIR and Direction are registered every clk, and targets are computed from the registered copy.
  - A target change is visible one cycle after the DIR change.
  - Applied duty changes only on PWM counter wrap (counter == PWM_PERIOD-1 going to 0), so there are no glitched pulses.
- Code map, given as (left duty/polarity, right duty/polarity), wheel-relative "F" = travel direction:
  - 0000 PROCEED: CRUISE F, CRUISE F.
  - 1001 VEER_RIGHT: CRUISE F, VEER F.
  - 1010 HARD_RIGHT: CRUISE F, HARD F.
  - 1011 NINETY_RIGHT: PIVOT F, PIVOT R.
  - 0101 VEER_LEFT: VEER F, CRUISE F.
  - 0110 HARD_LEFT: HARD F, CRUISE F.
  - 0111 NINETY_LEFT: PIVOT R, PIVOT F.
  - 1111 STOP: 0, 0.
  - Any other code: treated as STOP and cmd_err=1.
- Direction=0 inverts both wheel polarities; left/right duty assignment is unchanged.
- Ramp, evaluated at each wrap:
  - If target > applied: applied = min(applied+RAMP_STEP, target).
  - If target < applied: applied = target immediately (no ramp-down).
  - STOP takes effect at the next wrap regardless of ramp.
- PWM:
  - pwm = (counter < applied).
  - applied = 0 gives constant low.
  - applied >= PWM_PERIOD is clamped: constant high.
- Per-motor FSM:
  - RUN: fwd output = current polarity.
    - If target polarity != current polarity and target duty != 0: applied=0 immediately, PWM forced low, dead counter=0, go COAST.
  - COAST: dead counter increments each clk.
    - At DEADTIME-1: latch the new polarity, go RUN; applied restarts from 0 and ramps.
    - If the target polarity returns to the current polarity during COAST: go RUN with the current polarity, applied from 0.
    - A STOP target during COAST: remain COAST until expiry, then RUN with duty 0.
- Polarity changes with target duty 0 flip fwd directly in RUN (no COAST).
- The two motor FSMs are independent; simultaneous reversal of both wheels coasts both in parallel.
- Reset asserted mid-ramp or mid-COAST returns immediately to the reset values above.
- Width rules: duty and counter registers are wide enough for PWM_PERIOD; the ramp add saturates at PWM_PERIOD.

Optional Feature:
- Macro: MOTOR_PIVOT_WATCHDOG_EN.
- Defined:
  - A pivot counter runs while the registered DIR is NINETY_LEFT or NINETY_RIGHT.
  - On reaching PIVOT_TIMEOUT, both targets are forced to 0 and cmd_err=1.
  - This holds until the registered DIR takes any other value; the counter clears on any DIR change.
- Undefined: no counter; pivots are driven indefinitely; cmd_err reflects only undefined codes.

Test Plan:
Benches override PWM_PERIOD=100, RAMP_STEP=20, DEADTIME=10, CRUISE=70, VEER=40, HARD=10, PIVOT=60, PIVOT_TIMEOUT=500.
- Release reset, DIR=0000, Direction=1: applied duty per period 20,40,60,70,70; pwm high 70 of 100 cycles; both fwd=1; moving rises at the first wrap.
- At cruise, DIR=1010: right pwm high 10/100 from the next wrap (immediate drop); left stays 70; cmd_err=0.
- At cruise, DIR=1011: right pwm low, COAST 10 cycles, right fwd=0, right ramps 20,40,60; left drops to 60 at the next wrap.
- At cruise, toggle Direction 1→0: both motors coast 10 cycles, both fwd=0, both ramp back from 0 to 70.
- DIR=0011: both pwm low at the next wrap, cmd_err=1 one cycle after DIR change; DIR=0000 clears cmd_err; reset asserted mid-COAST forces all outputs to reset values within the same cycle.
- With MOTOR_PIVOT_WATCHDOG_EN, hold DIR=0111 for 600 cycles: both pwm low from the first wrap after cycle 500, cmd_err=1; DIR=0000 clears cmd_err and restarts the ramp.
